// File: rtl/ddr_pkg.sv
// ddr_pkg: encodings shared across the DDR command scheduler slice.
//   CMD_WR / CMD_RD : app_cmd encodings toward the memory controller
//   state_t         : scheduler FSM states
//   ptr_width()     : pointer width for a FIFO of a given depth (min 1 bit)
package ddr_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// ddr_sync_fifo: single-clock first-word-fall-through FIFO with occupancy count.
//   clk_if, resetn : clock, synchronous active-low reset (clears pointers/count)
//   push_i, push_data_i : write request and data; accepted when not full, or
//                         when full and popping in the same cycle
//   pop_i, pop_data_o   : read request; pop_data_o is the current head
//   empty_o, count_o    : status
module ddr_sync_fifo
  import ddr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_if,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_if) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_if) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: converts single-beat ram_cmd requests into memory
// controller app commands and returns read data in issue order.
//   clk_if, resetn        : clock, synchronous active-low reset
//   ram_cmd_*             : request beat (write wins if both enables high)
//   ram_rd_resp_*         : in-order read responses (valid/ready)
//   app_cmd*/app_addr     : controller command channel
//   app_wdf_*             : controller write data channel
//   app_rd_data*          : controller read data return
//   rd_outstanding        : reads issued and not yet returned by the controller
//   err_unexpected_rd     : sticky, read data arrived with no read in flight
//
// state | meaning
// INIT  | waiting for init_calib_complete
// IDLE  | ready to accept one request beat
// WR    | write command and/or write data handshake still pending
// RD    | read command handshake pending
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int APP_ADDR_WIDTH  = 29,
  parameter int ADDR_SHIFT      = 1,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_DEPTH      = 8
) (
  input  logic                              clk_if,
  input  logic                              resetn,
  input  logic [ID_WIDTH-1:0]               ram_cmd_id,
  input  logic [ADDR_WIDTH-1:0]             ram_cmd_addr,
  input  logic [DATA_WIDTH-1:0]             ram_cmd_wr_data,
  input  logic [DATA_WIDTH/8-1:0]           ram_cmd_wr_strb,
  input  logic                              ram_cmd_wr_en,
  input  logic                              ram_cmd_rd_en,
  input  logic                              ram_cmd_last,
  output logic                              ram_cmd_ready,
  output logic [ID_WIDTH-1:0]               ram_rd_resp_id,
  output logic [DATA_WIDTH-1:0]             ram_rd_resp_data,
  output logic                              ram_rd_resp_last,
  output logic                              ram_rd_resp_valid,
  input  logic                              ram_rd_resp_ready,
  output logic [2:0]                        app_cmd,
  output logic                              app_cmd_en,
  output logic [APP_ADDR_WIDTH-1:0]         app_addr,
  input  logic                              app_cmd_ready,
  input  logic                              init_calib_complete,
  output logic [DATA_WIDTH-1:0]             app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]           app_wdf_mask,
  output logic                              app_wdf_wren,
  output logic                              app_wdf_end,
  input  logic                              app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]             app_rd_data,
  input  logic                              app_rd_data_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]  rd_outstanding,
  output logic                              err_unexpected_rd
);

  localparam int OW     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RW     = $clog2(RESP_DEPTH) + 1;
  localparam int TAG_W  = ID_WIDTH + 1;
  localparam int RESP_W = ID_WIDTH + 1 + DATA_WIDTH;

  state_t                    state_q;
  logic                      cmd_en_q, cmd_en_d;
  logic [2:0]                cmd_q;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wren_q, wren_d;
  logic [DATA_WIDTH-1:0]     wdf_data_q;
  logic [DATA_WIDTH/8-1:0]   wdf_mask_q;
  logic                      err_q;

  logic [OW-1:0]     tag_count;
  logic [RW-1:0]     resp_count;
  logic              tag_empty, resp_empty;
  logic [TAG_W-1:0]  tag_head;
  logic [RESP_W-1:0] resp_head;
  logic              rd_credit, accept, accept_wr, accept_rd, rd_match, resp_pop;

  // A read needs a tag slot and a guaranteed response-buffer slot, so the
  // response buffer can never overflow while the controller returns data.
  assign rd_credit = (int'(tag_count) < MAX_OUTSTANDING) &&
                     (int'(tag_count) + int'(resp_count) < RESP_DEPTH);

  // Ready depends on the request type: writes do not consume read credit.
  assign ram_cmd_ready = (state_q == IDLE) & (ram_cmd_wr_en | rd_credit);
  assign accept        = (ram_cmd_wr_en | ram_cmd_rd_en) & ram_cmd_ready;
  assign accept_wr     = accept & ram_cmd_wr_en;
  assign accept_rd     = accept & ~ram_cmd_wr_en;
  assign rd_match      = app_rd_data_valid & ~tag_empty;
  assign resp_pop      = ~resp_empty & ram_rd_resp_ready;

  assign cmd_en_d = cmd_en_q & ~app_cmd_ready;
  assign wren_d   = wren_q & ~app_wdf_rdy;
  assign addr_d   = APP_ADDR_WIDTH'(ram_cmd_addr >> ADDR_SHIFT);

  always_ff @(posedge clk_if) begin
    if (!resetn) begin
      state_q    <= INIT;
      cmd_en_q   <= 1'b0;
      cmd_q      <= CMD_WR;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      wdf_data_q <= '0;
      wdf_mask_q <= '0;
    end else begin
      case (state_q)
        INIT: if (init_calib_complete) state_q <= IDLE;
        IDLE: begin
          if (accept) begin
            cmd_en_q <= 1'b1;
            addr_q   <= addr_d;
            cmd_q    <= accept_wr ? CMD_WR : CMD_RD;
            state_q  <= accept_wr ? WR : RD;
            if (accept_wr) begin
              wren_q     <= 1'b1;
              wdf_data_q <= ram_cmd_wr_data;
              wdf_mask_q <= ~ram_cmd_wr_strb;
            end
          end
        end
        // Command and data channels complete independently, in any order.
        WR: begin
          cmd_en_q <= cmd_en_d;
          wren_q   <= wren_d;
          if (!cmd_en_d && !wren_d) state_q <= IDLE;
        end
        RD: begin
          cmd_en_q <= cmd_en_d;
          if (!cmd_en_d) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk_if) begin
    if (!resetn)                             err_q <= 1'b0;
    else if (app_rd_data_valid && tag_empty) err_q <= 1'b1;
  end

  ddr_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_if      (clk_if),
    .resetn      (resetn),
    .push_i      (accept_rd),
    .push_data_i ({ram_cmd_id, ram_cmd_last}),
    .pop_i       (rd_match),
    .pop_data_o  (tag_head),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  ddr_sync_fifo #(.WIDTH(RESP_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk_if      (clk_if),
    .resetn      (resetn),
    .push_i      (rd_match),
    .push_data_i ({tag_head, app_rd_data}),
    .pop_i       (resp_pop),
    .pop_data_o  (resp_head),
    .empty_o     (resp_empty),
    .count_o     (resp_count)
  );

  assign app_cmd           = cmd_q;
  assign app_cmd_en        = cmd_en_q;
  assign app_addr          = addr_q;
  assign app_wdf_wren      = wren_q;
  assign app_wdf_end       = wren_q;
  assign app_wdf_data      = wdf_data_q;
  assign app_wdf_mask      = wdf_mask_q;
  assign ram_rd_resp_valid = ~resp_empty;
  assign ram_rd_resp_id    = resp_head[RESP_W-1 -: ID_WIDTH];
  assign ram_rd_resp_last  = resp_head[DATA_WIDTH];
  assign ram_rd_resp_data  = resp_head[DATA_WIDTH-1:0];
  assign rd_outstanding    = tag_count;
  assign err_unexpected_rd = err_q;

endmodule
